// File: rtl/div_sequencer_if.sv
// div_sequencer_if -- handshake bundle between execute-stage control and the
// iterative divider.
//   master : pipeline side, drives start/op/operands/flush and sees stall/busy/done/result
//   slave  : divider side
interface div_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, dividend, divisor, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer -- multi-cycle restoring radix-2 divider for DIV/DIVU/REM/REMU
// with pipeline stall generation.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : div_sequencer_if.slave
//          start/op/dividend/divisor/flush in, stall/busy/done/result out
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; operands latched on accept
// CALC   | one quotient bit per cycle, counter 0..31
// FINISH | one cycle, done=1 with result (unless flushed)
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  div_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  // quo holds the dividend magnitude; its MSBs shift out into the partial
  // remainder while quotient bits shift in at the LSB.
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept;
  logic            is_signed;
  logic            div_zero;
  logic            ovf;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;

  // Two's complement negate done at XLEN+1 bits so the most negative value
  // yields its correct unsigned magnitude.
  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
    logic [XLEN:0] t;
    t = (~{1'b0, x}) + {{XLEN{1'b0}}, 1'b1};
    return t[XLEN-1:0];
  endfunction

  assign accept    = (state_q == IDLE) && bus.start && !bus.flush;
  assign is_signed = ~bus.op[0];
  assign div_zero  = (bus.divisor == '0);
  assign ovf       = is_signed
                     && (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.divisor == '1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;

    rem_shift = {rem_q, quo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    q_bit     = ~diff[XLEN];
    rem_next  = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_next  = {quo_q[XLEN-2:0], q_bit};

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = bus.op;
          quo_d   = (is_signed && bus.dividend[XLEN-1]) ? negate(bus.dividend) : bus.dividend;
          dvs_d   = (is_signed && bus.divisor[XLEN-1])  ? negate(bus.divisor)  : bus.divisor;
          rem_d   = '0;
          cnt_d   = '0;
          q_neg_d = is_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
          r_neg_d = is_signed && bus.dividend[XLEN-1];
          if (div_zero) begin
            result_d = bus.op[1] ? bus.dividend : '1;
            state_d  = FINISH;
          end else if (ovf) begin
            // DIV overflow returns the dividend itself (most negative value)
            result_d = bus.op[1] ? '0 : bus.dividend;
            state_d  = FINISH;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          cnt_d    = '0;
          state_d  = FINISH;
          result_d = op_q[1] ? (r_neg_q ? negate(rem_next) : rem_next)
                             : (q_neg_q ? negate(quo_next) : quo_next);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush abandons the operation; result keeps its previous value.
    if (bus.flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  assign bus.stall  = accept || ((state_q == CALC) && !bus.flush);
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == FINISH) && !bus.flush;
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer -- directed and randomized checks of div_sequencer with a
// result/latency scoreboard fed at start and drained at done.
module tb_div_sequencer;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   k_start = 0;
  logic [31:0] last_res = '0;
  exp_t sb[$];

  div_sequencer_if #(.XLEN(32)) bus ();

  div_sequencer #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.dividend = a; bus.divisor = b;
    k_start = cyc;
    e.res = model(o, a, b);
    e.lat = is_special(o, a, b) ? 1 : 33;
    sb.push_back(e);
    #1;
    chk("stall_accept", bus.stall, 1'b1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic check_done(input string tag, input int nst);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_unexpected_done observed=done expected=none", tag);
      return;
    end
    e = sb.pop_front();
    last_res = e.res;
    chk({tag, "_result"}, bus.result, e.res);
    chk({tag, "_latency"}, 32'(cyc - k_start), 32'(e.lat));
    chk({tag, "_stall_cycles"}, 32'(nst), 32'(e.lat));
    chk({tag, "_stall_at_done"}, bus.stall, 1'b0);
    chk({tag, "_busy_at_done"}, bus.busy, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int nst;
    bit got;
    nst = 1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        check_done(tag, nst);
      end else if (bus.stall) begin
        nst++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no_done expected=done", tag);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      @(negedge clk);
      chk({tag, "_done_low_after"}, bus.done, 1'b0);
      chk({tag, "_result_held"}, bus.result, last_res);
      chk({tag, "_idle_after"}, bus.busy, 1'b0);
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start_op(o, a, b);
    wait_done(tag);
  endtask

  initial begin
    int ndone;
    int nst;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.dividend = '0; bus.divisor = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, 32'h0);
    rst = 1'b0;

    // signed divide/remainder with negative dividend
    do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2_value", last_res, 32'hFFFF_FFFD);
    do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("rem_m7_2_value", last_res, 32'hFFFF_FFFF);

    // divide by zero and signed overflow take the short path
    do_op("divu_by0", 2'b01, 32'd100, 32'd0);
    chk("divu_by0_value", last_res, 32'hFFFF_FFFF);
    do_op("remu_by0", 2'b11, 32'd100, 32'd0);
    chk("remu_by0_value", last_res, 32'd100);
    do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_value", last_res, 32'h8000_0000);
    do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("rem_ovf_value", last_res, 32'h0);

    // start pulses during CALC are ignored
    start_op(2'b11, 32'hFFFF_FFFF, 32'h10);
    ndone = 0;
    nst = 1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (cyc == k_start + 5 || cyc == k_start + 20) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.dividend = 32'd5; bus.divisor = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      if (bus.done) begin
        ndone++;
        check_done("remu_ign", nst);
      end else if (bus.stall) begin
        nst++;
      end
    end
    bus.start = 1'b0;
    chk("remu_ign_done_count", 32'(ndone), 32'd1);
    chk("remu_ign_value", last_res, 32'hF);

    // flush mid-CALC, then a fresh operation
    start_op(2'b01, 32'd1000, 32'd7);
    ndone = 0;
    while (cyc < k_start + 10) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", bus.stall, 1'b0);
    chk("flush_done", bus.done, 1'b0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("flush_idle", bus.busy, 1'b0);
    chk("flush_no_done", 32'(ndone) | 32'(bus.done), 32'd0);
    do_op("divu_after_flush", 2'b01, 32'd1000, 32'd7);
    chk("divu_after_flush_value", last_res, 32'd142);

    // reset mid-CALC
    start_op(2'b00, 32'd1000, 32'd3);
    while (cyc < k_start + 15) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("mid_rst_stall", bus.stall, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_done", bus.done, 1'b0);
    chk("mid_rst_result", bus.result, 32'h0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("mid_rst_no_done", 32'(ndone), 32'd0);
    do_op("div_after_rst", 2'b00, 32'd1000, 32'hFFFF_FFFD);
    do_op("rem_after_rst", 2'b10, 32'hFFFF_FC18, 32'd7);

    // randomized operations against the reference model
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i == 7) rb = 32'h0;
      do_op("rand", ro, ra, rb);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a divide in this cycle (from execute-stage control decode).
REQ-005 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 dividend  input  32  left operand (post-forwarding value).
REQ-007 divisor  input  32  right operand (post-forwarding value).
REQ-008 flush  input  1  abort in-flight operation (branch taken / pipeline flush).
REQ-009 stall  output  1  hold fetch/decode/execute; insert bubble downstream.
REQ-010 busy  output  1  high while state is not IDLE.
REQ-011 done  output  1  one-cycle pulse; result valid in this cycle.
REQ-012 result  output  32  quotient (DIV/DIVU) or remainder (REM/REMU).

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FINISH.
REQ-014 In IDLE, start=1 and flush=0 SHALL latch op, operands and operand signs; next state SHALL be CALC, or FINISH for special cases (REQ-019, REQ-020).
REQ-015 start SHALL be ignored in CALC and FINISH; no queuing.
REQ-016 CALC SHALL perform restoring radix-2 division, one quotient bit per cycle, over a 6-bit iteration counter running 0..31, and leave to FINISH after the 32nd iteration.
REQ-017 For DIV/REM, magnitudes SHALL be divided; quotient SHALL be negated when operand signs differ; remainder SHALL take the sign of the dividend. DIVU/REMU SHALL use unsigned operands unchanged.
REQ-018 FINISH SHALL last exactly one cycle, drive done=1 with result, and return to IDLE.
REQ-019 Divisor zero: result SHALL be 0xFFFFFFFF for DIV/DIVU and the dividend for REM/REMU, with no CALC cycles.
REQ-020 Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): result SHALL be 0x80000000 for DIV and 0 for REM, with no CALC cycles.
REQ-021 Latency: start accepted in cycle k: normal ops SHALL give done in cycle k+33; special cases SHALL give done in cycle k+1.
REQ-022 stall SHALL be combinational: 1 in the accept cycle (IDLE, start=1, flush=0) and in every CALC cycle; 0 in FINISH and otherwise.
REQ-023 result SHALL hold its last value after done until the next FINISH; done SHALL never be asserted outside FINISH.
REQ-024 flush=1 in any state SHALL force IDLE next cycle, suppress done and force stall=0 in that cycle; start with flush in the same cycle SHALL be dropped.
REQ-025 No arithmetic SHALL exceed 33 bits of partial remainder; negation of 0x80000000 magnitude SHALL be computed in 33-bit unsigned form.

Reset
REQ-026 rst=1 at an edge SHALL set state IDLE, counter 0, stall 0, busy 0, done 0, result 0x00000000, overriding start and flush.
REQ-027 rst asserted mid-CALC SHALL abort the operation with no done pulse.

Verification
REQ-028 DIV 0xFFFFFFF9 (-7) / 2, start in cycle 0 -> stall cycles 0-32, done in cycle 33, result 0xFFFFFFFD (-3); REM gives 0xFFFFFFFF (-1).
REQ-029 DIVU 100 / 0 -> done in cycle 1, result 0xFFFFFFFF; REMU 100 / 0 -> result 100.
REQ-030 DIV 0x80000000 / 0xFFFFFFFF -> done in cycle 1, result 0x80000000; REM -> 0.
REQ-031 REMU 0xFFFFFFFF / 0x10 -> done in cycle 33, result 0xF; start pulses in cycles 5 and 20 ignored, one done only.
REQ-032 DIVU 1000 / 7 with flush in cycle 10 -> IDLE in cycle 11, no done, stall 0 in cycle 10; new DIVU 1000 / 7 at cycle 12 -> done cycle 45, result 142.
REQ-033 rst in cycle 15 of a DIV -> all outputs zero next cycle, no done; later operations correct.
